// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Ports: clk, rst (sync, active-high); start/signed_div/flush/opa/opb issue and
// cancel a divide; stall_div holds the pipeline; ready pulses when hi/lo are valid.
// hi = remainder, lo = quotient.
// Optional: define DIV_EARLY_EXIT_EN to finish in one cycle when |opa| < |opb|.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_rem;
    logic [WIDTH-1:0]   r_div;
    logic               r_qneg;
    logic               r_rneg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_ready;

    logic [WIDTH-1:0]   w_absa;
    logic [WIDTH-1:0]   w_absb;
    logic [WIDTH:0]     w_up;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign w_absa = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    assign w_absb = (signed_div && opb[WIDTH-1]) ? -opb : opb;

    // Shifted upper half needs WIDTH+1 bits: 2*rem+1 can exceed WIDTH bits.
    assign w_up   = r_rem[2*WIDTH-1:WIDTH-1];
    assign w_ge   = (w_up >= {1'b0, r_div});
    // True difference is below the divisor, so WIDTH bits suffice.
    assign w_diff = w_up[WIDTH-1:0] - r_div;

    assign w_rem_nxt = {w_ge ? w_diff : w_up[WIDTH-1:0],
                        r_rem[WIDTH-2:0], w_ge};
    assign w_q = w_rem_nxt[WIDTH-1:0];
    assign w_r = w_rem_nxt[2*WIDTH-1:WIDTH];

    assign stall_div = ((r_state == S_IDLE) && start && !flush)
                     || (r_state == S_BUSY);
    assign ready = r_ready;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_div  <= w_absb;
                        r_rem  <= {{WIDTH{1'b0}}, w_absa};
                        r_qneg <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_rneg <= signed_div & opa[WIDTH-1];
                        if (opb == '0) begin
                            r_lo    <= '1;
                            r_hi    <= opa;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (w_absa < w_absb) begin
                            r_lo    <= '0;
                            r_hi    <= opa;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
`endif
                        else begin
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_lo    <= r_qneg ? -w_q : w_q;
                            r_hi    <= r_rneg ? -w_r : w_r;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Result already committed; start still high must not retrigger.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized divides
// compared against a plain-arithmetic model.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic         flush;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         stall_div;
    logic         ready;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] prev_lo;
    logic [W-1:0] prev_hi;

    div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .flush(flush), .opa(opa), .opb(opb), .stall_div(stall_div),
        .ready(ready), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn, output logic [W-1:0] elo,
                                  output logic [W-1:0] ehi, output int elat);
        longint sa, sb, q, r, ma, mb;
        if (b == '0) begin
            elo = '1; ehi = a; elat = 1;
            return;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        elo = q[W-1:0];
        ehi = r[W-1:0];
        elat = W + 1;
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) elat = 1;
`else
        if (ma < mb) elat = W + 1;
`endif
    endfunction

    // Drives one divide and reports what was observed. chain_in: already at
    // the start of the issue cycle. chain_out: return right after the ready
    // cycle with start still high.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input int exp_lat,
                          input bit chain_in, input bit chain_out,
                          output int lat, output int nrdy, output int stall_bad,
                          output logic [W-1:0] olo, output logic [W-1:0] ohi);
        if (!chain_in) begin
            @(posedge clk); #1;
        end
        start = 1'b1; signed_div = sgn; opa = a; opb = b;
        lat = -1; nrdy = 0; stall_bad = 0; olo = 'x; ohi = 'x;
        for (int k = 0; k <= W + 3; k++) begin
            @(negedge clk);
            if (stall_div !== (k < exp_lat)) stall_bad++;
            if (ready === 1'b1) begin
                if (lat < 0) lat = k;
                nrdy++;
                olo = lo;
                ohi = hi;
            end
            @(posedge clk); #1;
            if (lat >= 0 && chain_out) return;
            if (lat >= 0) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; signed_div = 0; flush = 0; opa = 0; opb = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: stall=%b ready=%b want 0 0", stall_div, ready);
        end
        n_checks++;
        if (hi !== '0 || lo !== '0) begin
            n_errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo);
        end
        prev_hi = '0; prev_lo = '0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6], tb_ [6], tlo [6], thi [6];
        logic ts [6];
        int tl [6];
        int lat, nr, sb;
        logic [W-1:0] olo, ohi;
        ta[0] = 100;          tb_[0] = 7;            ts[0] = 0; tlo[0] = 14;           thi[0] = 2;            tl[0] = 33;
        ta[1] = 32'hFFFFFFF9; tb_[1] = 2;            ts[1] = 1; tlo[1] = 32'hFFFFFFFD; thi[1] = 32'hFFFFFFFF; tl[1] = 33;
        ta[2] = 7;            tb_[2] = 32'hFFFFFFFE; ts[2] = 1; tlo[2] = 32'hFFFFFFFD; thi[2] = 1;            tl[2] = 33;
        ta[3] = 32'h80000000; tb_[3] = 32'hFFFFFFFF; ts[3] = 1; tlo[3] = 32'h80000000; thi[3] = 0;            tl[3] = 33;
        ta[4] = 5;            tb_[4] = 0;            ts[4] = 0; tlo[4] = 32'hFFFFFFFF; thi[4] = 5;            tl[4] = 1;
`ifdef DIV_EARLY_EXIT_EN
        ta[5] = 3;            tb_[5] = 10;           ts[5] = 0; tlo[5] = 0;            thi[5] = 3;            tl[5] = 1;
`else
        ta[5] = 3;            tb_[5] = 10;           ts[5] = 0; tlo[5] = 0;            thi[5] = 3;            tl[5] = 33;
`endif
        for (int i = 0; i < 6; i++) begin
            do_div(ta[i], tb_[i], ts[i], tl[i], 0, 0, lat, nr, sb, olo, ohi);
            n_checks++;
            if (lat != tl[i] || nr != 1) begin
                n_errors++;
                $display("FAIL dir%0d_latency: ready at %0d x%0d want %0d x1", i, lat, nr, tl[i]);
            end
            n_checks++;
            if (sb != 0) begin
                n_errors++;
                $display("FAIL dir%0d_stall: %0d bad cycles want 0", i, sb);
            end
            n_checks++;
            if (olo !== tlo[i] || ohi !== thi[i]) begin
                n_errors++;
                $display("FAIL dir%0d_result: lo=%h hi=%h want lo=%h hi=%h", i, olo, ohi, tlo[i], thi[i]);
            end
            prev_lo = tlo[i]; prev_hi = thi[i];
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (hi !== prev_hi || lo !== prev_lo || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL hold%0d: hi=%h lo=%h rdy=%b want %h %h 0", i, hi, lo, ready, prev_hi, prev_lo);
            end
        end
    endtask

    task automatic test_flush();
        int nr0, lat, nr, sb, elat;
        logic [W-1:0] olo, ohi, elo, ehi;
        nr0 = 0;
        @(posedge clk); #1;
        start = 1; signed_div = 0; opa = 1000; opb = 3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready === 1'b1) nr0++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (ready === 1'b1) nr0++;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        if (ready === 1'b1) nr0++;
        n_checks++;
        if (stall_div !== 1'b0 || nr0 != 0) begin
            n_errors++;
            $display("FAIL flush_abort: stall=%b readies=%0d want 0 0", stall_div, nr0);
        end
        n_checks++;
        if (hi !== prev_hi || lo !== prev_lo) begin
            n_errors++;
            $display("FAIL flush_hilo: hi=%h lo=%h want %h %h", hi, lo, prev_hi, prev_lo);
        end
        model(32'd1000, 32'd3, 1'b0, elo, ehi, elat);
        do_div(32'd1000, 32'd3, 1'b0, elat, 0, 0, lat, nr, sb, olo, ohi);
        n_checks++;
        if (lat != elat || nr != 1 || sb != 0 || olo !== elo || ohi !== ehi) begin
            n_errors++;
            $display("FAIL flush_restart: lat=%0d n=%0d sb=%0d lo=%h hi=%h want %0d 1 0 %h %h",
                     lat, nr, sb, olo, ohi, elat, elo, ehi);
        end
        prev_lo = elo; prev_hi = ehi;
    endtask

    task automatic test_back_to_back();
        int lat, nr, sb, elat1, elat2;
        logic [W-1:0] olo, ohi, elo1, ehi1, elo2, ehi2;
        model(32'd1000, 32'd7, 1'b0, elo1, ehi1, elat1);
        model(32'hFFFFFC18, 32'd9, 1'b1, elo2, ehi2, elat2);
        do_div(32'd1000, 32'd7, 1'b0, elat1, 0, 1, lat, nr, sb, olo, ohi);
        n_checks++;
        if (lat != elat1 || sb != 0 || olo !== elo1 || ohi !== ehi1) begin
            n_errors++;
            $display("FAIL b2b_first: lat=%0d sb=%0d lo=%h hi=%h want %0d 0 %h %h",
                     lat, sb, olo, ohi, elat1, elo1, ehi1);
        end
        do_div(32'hFFFFFC18, 32'd9, 1'b1, elat2, 1, 0, lat, nr, sb, olo, ohi);
        n_checks++;
        if (lat != elat2 || nr != 1 || sb != 0 || olo !== elo2 || ohi !== ehi2) begin
            n_errors++;
            $display("FAIL b2b_second: lat=%0d n=%0d sb=%0d lo=%h hi=%h want %0d 1 0 %h %h",
                     lat, nr, sb, olo, ohi, elat2, elo2, ehi2);
        end
        prev_lo = elo2; prev_hi = ehi2;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, olo, ohi, elo, ehi;
        logic s;
        int lat, nr, sb, elat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = $urandom_range(1, 15);
                1: b = '0;
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
                3: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
                4: b = (($urandom_range(0, 1)) != 0) ? 32'd1 : 32'hFFFFFFFF;
                default: ;
            endcase
            model(a, b, s, elo, ehi, elat);
            do_div(a, b, s, elat, 0, 0, lat, nr, sb, olo, ohi);
            n_checks++;
            if (lat != elat || nr != 1 || sb != 0) begin
                n_errors++;
                $display("FAIL rnd%0d_timing: lat=%0d n=%0d sb=%0d want %0d 1 0", i, lat, nr, sb, elat);
            end
            n_checks++;
            if (olo !== elo || ohi !== ehi) begin
                n_errors++;
                $display("FAIL rnd%0d_result a=%h b=%h s=%b: lo=%h hi=%h want %h %h",
                         i, a, b, s, olo, ohi, elo, ehi);
            end
            prev_lo = elo; prev_hi = ehi;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1; signed_div = 0; opa = 1000; opb = 3;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_div !== 1'b0 || ready !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: stall=%b ready=%b hi=%h lo=%h want 0 0 0 0",
                     stall_div, ready, hi, lo);
        end
        repeat (40) begin
            @(negedge clk);
            n_checks++;
            if (stall_div !== 1'b0 || ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_quiet: stall=%b ready=%b want 0 0", stall_div, ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_back_to_back();
        test_random();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer and iterative radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in the execute stage beside the ALU.
- Accepts a divide issued in E and holds the pipeline with a stall request until the quotient and remainder are ready.
- Delivers {HI=remainder, LO=quotient} for the HI/LO write.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even); the iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  divide instruction present in E stage; held high by the pipeline while stalled
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- flush  in  1  cancel the in-flight divide (exception or E flush)
- opa  in  WIDTH  dividend (rs), sampled with start
- opb  in  WIDTH  divisor (rt), sampled with start
- stall_div  out  1  pipeline stall request to the hazard logic
- ready  out  1  one-cycle pulse: hi/lo valid
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (sync, rst=1 at a clock edge): state=IDLE, counter=0, hi=0, lo=0, ready=0. stall_div=0 from the following cycle. Reset overrides everything, including mid-BUSY.
- stall_div = (IDLE & start & ~flush) | BUSY. Combinational, so the issuing cycle T is already stalled. Low in DONE, so the pipeline advances on the DONE cycle.
- IDLE:
  - start & ~flush at edge T → latch |opa|, |opb| (absolute values only when signed_div), quotient sign = opa[MSB]^opb[MSB], remainder sign = opa[MSB] (signed only).
  - opb==0 → DONE at T+1.
  - Otherwise → BUSY with counter=WIDTH.
  - start & flush → stay IDLE.
- BUSY:
  - Each cycle performs one restoring step on a 2·WIDTH partial-remainder register: shift left 1; if upper half ≥ divisor, subtract and set quotient bit to 1, else 0. Counter decrements.
  - After WIDTH steps (cycles T+1..T+WIDTH) → DONE at T+WIDTH+1.
  - flush in BUSY → IDLE next edge, no ready, hi/lo unchanged.
- DONE:
  - ready=1 for exactly this cycle.
  - hi/lo hold the signed-corrected results: quotient negated if the quotient sign is 1; remainder negated if the remainder sign is 1.
  - Next edge → IDLE unconditionally. start is still high this cycle and must NOT retrigger.
  - flush in DONE is ignored; the result is already committed.
- hi/lo remain stable until the next DONE or reset.
- Divide by zero: lo = all ones, hi = opa (raw dividend); latency 1 (ready at T+1).
- Signed overflow (most-negative / −1): lo = most-negative value (wraps), hi = 0; no trap.
- Arithmetic: absolute values computed in WIDTH bits. |most-negative| is treated as the unsigned magnitude 2^(WIDTH−1), which is correct under the unsigned datapath.
- Latency, non-zero divisor: start at T → ready at T+WIDTH+1 (T+33 for WIDTH=32). Back-to-back divides: the second start is seen in IDLE at T+WIDTH+2 at the earliest.

Optional Feature:
- DIV_EARLY_EXIT_EN
- Defined: in IDLE, if opb≠0 and |opa| < |opb| (unsigned compare of magnitudes), go directly to DONE at T+1 with lo=0 and hi=opa (sign preserved), skipping BUSY.
- Undefined: all non-zero-divisor divides take the full WIDTH+1-cycle path. Results are identical either way; only latency differs.

Test Plan:
- DIVU opa=100, opb=7, start at T → stall_div high T..T+32, ready at T+33 only, lo=14, hi=2; stall_div low at T+33; no second ready although start stays high at T+33.
- DIV opa=0xFFFFFFF9 (−7), opb=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1) at T+33. DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
- DIV opa=0x80000000, opb=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → ready at T+1, lo=0xFFFFFFFF, hi=5, stall_div high only in cycle T.
- Start 1000/3, assert flush at T+10 → stall_div low from T+11, no ready pulse, hi/lo keep previous values; a new start at T+12 completes normally (ready at T+45).
- rst asserted at T+5 of an active divide → at T+6 state IDLE, stall_div=0, ready=0, hi=lo=0.
- With DIV_EARLY_EXIT_EN: DIVU 3/10 → ready at T+1, lo=0, hi=3. Without the macro → same values at T+33.
